// File: rtl/pipelined_decoder.sv
// Registered N-to-2**N one-hot decoder with valid/ready handshake.
// Define DEC_SCAN_EN to add the walking-one scan FSM (scan, scan_busy).
module pipelined_decoder #(
   parameter int N       = 3,
   parameter int ACT_LOW = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    a,
   input  logic            en,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [2**N-1:0] y,
   output logic            out_valid,
   input  logic            out_ready
`ifdef DEC_SCAN_EN
   ,
   input  logic            scan,
   output logic            scan_busy
`endif
);

   localparam int W = 2**N;
   localparam logic [N-1:0] TOP = {N{1'b1}};

   logic [W-1:0] dec_q;
   logic         accept;
   logic         xfer;

   function automatic logic [W-1:0] onehot(input logic [N-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

   assign accept = in_valid && in_ready;
   assign xfer   = out_valid && out_ready;
   assign y      = (ACT_LOW != 0) ? ~dec_q : dec_q;

`ifdef DEC_SCAN_EN
   typedef enum logic {IDLE, SCAN} state_t;

   state_t       state;
   logic [N-1:0] cnt;
   logic [N-1:0] cnt_nxt;

   assign scan_busy = (state == SCAN);
   assign in_ready  = (!out_valid || out_ready) && !scan_busy;
   assign cnt_nxt   = cnt + 1'b1;

   // No accept can occur in SCAN, so a transfer there always advances cnt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         dec_q     <= '0;
         out_valid <= 1'b0;
      end else if (accept) begin
         dec_q     <= en ? onehot(a) : '0;
         out_valid <= 1'b1;
         if (scan && en && (a != TOP)) begin
            state <= SCAN;
            cnt   <= a;
         end
      end else if (xfer) begin
         if (state == SCAN) begin
            dec_q <= onehot(cnt_nxt);
            cnt   <= cnt_nxt;
            if (cnt_nxt == TOP) begin
               state <= IDLE;
            end
         end else begin
            dec_q     <= '0;
            out_valid <= 1'b0;
         end
      end
   end
`else
   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_q     <= '0;
         out_valid <= 1'b0;
      end else if (accept) begin
         dec_q     <= en ? onehot(a) : '0;
         out_valid <= 1'b1;
      end else if (xfer) begin
         dec_q     <= '0;
         out_valid <= 1'b0;
      end
   end
`endif

endmodule
